cmos_capture: RTL

Camera capture front end that consumes the 8-bit CMOS byte stream (cmos_data/cmos_href/cmos_vsyn) on the pixel clock and produces one RGB565 pixel per two bytes, tagged with x/y coordinates and frame markers. It sits directly downstream of the camera interface, or of the camera model in simulation, and feeds the frame-buffer write path toward SDRAM.
- Discards the first SKIP_FRAMES frames after reset while the sensor settles.
- Flags malformed lines and frames.

---
 rtl/cmos_capture.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/cmos_capture.sv
// CMOS camera capture front end: assembles byte pairs into RGB565 pixels with
// x/y coordinates, frame markers and malformed line/frame detection.
module cmos_capture #(
  parameter int unsigned H_ACT       = 800,
  parameter int unsigned V_ACT       = 480,
  parameter int unsigned SKIP_FRAMES = 2
) (
  input  logic        cmos_pclk,
  input  logic        rst,
  input  logic [7:0]  cmos_data,
  input  logic        cmos_href,
  input  logic        cmos_vsyn,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        frame_done,
  output logic        frame_err,
  output logic        line_err,
  output logic [15:0] frame_cnt
);

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned SW = 8;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    BLANK   = 2'd1,
    SKIP    = 2'd2,
    ACTIVE  = 2'd3
  } state_t;

  state_t        state;
  logic          vs_d;
  logic          hr_d;
  logic          phase_lo;
  logic          line_ovf;
  logic          ferr;
  logic [7:0]    hi_byte;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] line_cnt;
  logic [SW-1:0] skip_cnt;

  logic          vs_rise;
  logic          vs_fall;
  logic          hr_fall;
  logic          active;
  logic          line_full;
  logic          x_full;
  logic          cap;
  logic          line_done;
  logic          odd_end;
  logic          frame_bad;
  logic [YW-1:0] line_cnt_nxt;

  // Edge detection against the previous-cycle copies of the sync inputs.
  assign vs_rise = cmos_vsyn & ~vs_d;
  assign vs_fall = ~cmos_vsyn & vs_d;
  assign hr_fall = ~cmos_href & hr_d;

  // Capture qualifiers; a vsyn rise aborts the line so its byte is not taken.
  assign active    = (state == ACTIVE);
  assign line_full = (line_cnt >= YW'(V_ACT));
  assign x_full    = (x_cnt >= XW'(H_ACT));
  assign cap       = active & cmos_href & ~vs_rise & ~line_full;
  assign line_done = active & hr_fall & (x_cnt != '0);
  assign odd_end   = hr_fall & phase_lo;

  // Line count including a line that ends in this same cycle.
  assign line_cnt_nxt = line_cnt + YW'(line_done);

  // Frame is bad on any sticky error, a dangling byte now, an aborted line,
  // or a line count other than V_ACT.
  assign frame_bad = ferr | odd_end | cmos_href | (line_cnt_nxt != YW'(V_ACT));

  // Frame FSM, byte assembly, coordinate counters and registered outputs.
  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      state       <= WAIT_VS;
      vs_d        <= 1'b0;
      hr_d        <= 1'b0;
      phase_lo    <= 1'b0;
      line_ovf    <= 1'b0;
      ferr        <= 1'b0;
      hi_byte     <= '0;
      x_cnt       <= '0;
      line_cnt    <= '0;
      skip_cnt    <= '0;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      line_err    <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      vs_d        <= cmos_vsyn;
      hr_d        <= cmos_href;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
      line_err    <= 1'b0;

      if (!cmos_href || vs_rise || vs_fall) begin
        phase_lo <= 1'b0;
      end else if (cap) begin
        phase_lo <= ~phase_lo;
      end

      case (state)
        WAIT_VS: begin
          if (cmos_vsyn) state <= BLANK;
        end

        BLANK: begin
          if (vs_fall) begin
            if (skip_cnt < SW'(SKIP_FRAMES)) begin
              state <= SKIP;
            end else begin
              state       <= ACTIVE;
              frame_start <= 1'b1;
              pix_y       <= '0;
              x_cnt       <= '0;
              line_cnt    <= '0;
              line_ovf    <= 1'b0;
              ferr        <= 1'b0;
            end
          end
        end

        SKIP: begin
          if (vs_rise) begin
            if (skip_cnt < SW'(SKIP_FRAMES)) skip_cnt <= skip_cnt + SW'(1);
            state <= BLANK;
          end
        end

        ACTIVE: begin
          if (cap && !phase_lo) hi_byte <= cmos_data;

          if (cap && phase_lo) begin
            if (!x_full) begin
              pix_valid <= 1'b1;
              pix_data  <= {hi_byte, cmos_data};
              pix_x     <= x_cnt;
              pix_y     <= line_cnt;
              x_cnt     <= x_cnt + XW'(1);
            end else if (!line_ovf) begin
              line_ovf <= 1'b1;
              line_err <= 1'b1;
              ferr     <= 1'b1;
            end
          end

          // Any line activity once V_ACT lines are done marks an overlong frame.
          if (cmos_href && line_full) ferr <= 1'b1;

          if (hr_fall) begin
            x_cnt    <= '0;
            pix_x    <= '0;
            line_ovf <= 1'b0;
            line_cnt <= line_cnt_nxt;
            if (phase_lo) begin
              line_err <= 1'b1;
              ferr     <= 1'b1;
            end
          end

          if (vs_rise) begin
            frame_done <= 1'b1;
            frame_err  <= frame_bad;
            frame_cnt  <= frame_cnt + 16'(1);
            state      <= BLANK;
          end
        end

        default: state <= WAIT_VS;
      endcase
    end
  end

endmodule
